// File: rtl/rbfu_pipe.sv
// Multi-lane reconfigurable NTT/INTT/PWM butterfly unit; opcode travels with its data.
// Latency MUL_LAT+2 cycles after accept (input reg, pre-op reg, MUL_LAT multiplier regs, output reg).
// Whole pipe freezes while the output is held (out_valid && !out_ready); in_ready mirrors that enable.
module rbfu_pipe #(
    parameter int DATA_WIDTH = 12,
    parameter int Q          = 3329,
    parameter int PAIRS      = 2,
    parameter int MUL_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [1:0]                  opcode,
    input  logic [PAIRS*DATA_WIDTH-1:0] a0,
    input  logic [PAIRS*DATA_WIDTH-1:0] b0,
    input  logic [PAIRS*DATA_WIDTH-1:0] w0,
    input  logic [PAIRS*DATA_WIDTH-1:0] a1,
    input  logic [PAIRS*DATA_WIDTH-1:0] b1,
    input  logic [PAIRS*DATA_WIDTH-1:0] w1,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PAIRS*DATA_WIDTH-1:0] dout0,
    output logic [PAIRS*DATA_WIDTH-1:0] dout1,
    output logic [PAIRS*DATA_WIDTH-1:0] dout2,
    output logic [PAIRS*DATA_WIDTH-1:0] dout3,
    output logic [1:0]                  out_opcode,
    output logic                        busy
);

    localparam int W = DATA_WIDTH;
    localparam int P = PAIRS;
    localparam int L = MUL_LAT;
    localparam logic [W:0]     QW = (W+1)'(Q);
    localparam logic [2*W-1:0] QP = (2*W)'(Q);
    localparam logic [1:0] OP_NTT  = 2'b00;
    localparam logic [1:0] OP_INTT = 2'b01;
    localparam logic [1:0] OP_PWM0 = 2'b10;

    typedef logic [P-1:0][W-1:0] vec_t;

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QW) s = s - QW;
        return W'(s);
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} - {1'b0, y};
        if (x < y) s = s + QW;
        return W'(s);
    endfunction

    // Division by 2 mod odd Q: odd values borrow one Q to become even first.
    function automatic logic [W-1:0] mod_half(input logic [W-1:0] x);
        logic [W:0] s;
        s = x[0] ? ({1'b0, x} + QW) : {1'b0, x};
        return W'(s >> 1);
    endfunction

    function automatic logic [W-1:0] mod_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] pr;
        pr = (2*W)'(x) * (2*W)'(y);
        return W'(pr % QP);
    endfunction

    logic       en;
    logic       s0_vld, s1_vld;
    logic [1:0] s0_op, s1_op;
    vec_t       s0_a0, s0_b0, s0_w0, s0_a1, s0_b1, s0_w1;
    vec_t       s1_x0, s1_y0, s1_x1, s1_y1, s1_p0, s1_p1;
    vec_t       pre_x0, pre_y0, pre_x1, pre_y1, pre_p0, pre_p1;
    vec_t       prod0, prod1;
    logic [L-1:0] m_vld;
    logic [1:0] m_op [L];
    vec_t       m_m0 [L];
    vec_t       m_m1 [L];
    vec_t       m_p0 [L];
    vec_t       m_p1 [L];
    vec_t       post_d0, post_d1, post_d2, post_d3;
    vec_t       out_d0, out_d1, out_d2, out_d3;

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign busy     = s0_vld | s1_vld | (|m_vld) | out_valid;
    assign dout0    = out_d0;
    assign dout1    = out_d1;
    assign dout2    = out_d2;
    assign dout3    = out_d3;

    // Route operands to the two multipliers (x*y) and the two bypass lanes (p) of each pair.
    always_comb begin
        pre_x0 = '0; pre_y0 = '0; pre_x1 = '0; pre_y1 = '0; pre_p0 = '0; pre_p1 = '0;
        for (int p = 0; p < P; p++) begin
            case (s0_op)
                OP_NTT: begin
                    pre_x0[p] = s0_b0[p];  pre_y0[p] = s0_w0[p];
                    pre_x1[p] = s0_b1[p];  pre_y1[p] = s0_w1[p];
                    pre_p0[p] = s0_a0[p];  pre_p1[p] = s0_a1[p];
                end
                OP_INTT: begin
                    pre_x0[p] = mod_sub(s0_b0[p], s0_a0[p]);  pre_y0[p] = s0_w0[p];
                    pre_x1[p] = mod_sub(s0_b1[p], s0_a1[p]);  pre_y1[p] = s0_w1[p];
                    pre_p0[p] = mod_add(s0_a0[p], s0_b0[p]);
                    pre_p1[p] = mod_add(s0_a1[p], s0_b1[p]);
                end
                OP_PWM0: begin
                    pre_x0[p] = s0_a0[p];  pre_y0[p] = s0_a1[p];
                    pre_x1[p] = s0_b0[p];  pre_y1[p] = s0_b1[p];
                    pre_p0[p] = mod_add(s0_a0[p], s0_b0[p]);
                    pre_p1[p] = mod_add(s0_a1[p], s0_b1[p]);
                end
                default: begin
                    pre_x0[p] = s0_b1[p];  pre_y0[p] = s0_w1[p];
                    pre_x1[p] = s0_a0[p];  pre_y1[p] = s0_b0[p];
                    pre_p0[p] = s0_a1[p];
                    pre_p1[p] = mod_add(s0_a1[p], s0_b1[p]);
                end
            endcase
        end
    end

    always_comb begin
        prod0 = '0; prod1 = '0;
        for (int p = 0; p < P; p++) begin
            prod0[p] = mod_mul(s1_x0[p], s1_y0[p]);
            prod1[p] = mod_mul(s1_x1[p], s1_y1[p]);
        end
    end

    always_comb begin
        post_d0 = '0; post_d1 = '0; post_d2 = '0; post_d3 = '0;
        for (int p = 0; p < P; p++) begin
            case (m_op[L-1])
                OP_NTT: begin
                    post_d0[p] = mod_add(m_p0[L-1][p], m_m0[L-1][p]);
                    post_d1[p] = mod_sub(m_p0[L-1][p], m_m0[L-1][p]);
                    post_d2[p] = mod_add(m_p1[L-1][p], m_m1[L-1][p]);
                    post_d3[p] = mod_sub(m_p1[L-1][p], m_m1[L-1][p]);
                end
                OP_INTT: begin
                    post_d0[p] = mod_half(m_p0[L-1][p]);
                    post_d1[p] = mod_half(m_m0[L-1][p]);
                    post_d2[p] = mod_half(m_p1[L-1][p]);
                    post_d3[p] = mod_half(m_m1[L-1][p]);
                end
                OP_PWM0: begin
                    post_d0[p] = m_p0[L-1][p];
                    post_d1[p] = m_p1[L-1][p];
                    post_d2[p] = m_m0[L-1][p];
                    post_d3[p] = m_m1[L-1][p];
                end
                default: begin
                    post_d0[p] = mod_add(m_p0[L-1][p], m_m0[L-1][p]);
                    post_d1[p] = mod_sub(m_m1[L-1][p], m_p1[L-1][p]);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_vld <= 1'b0; s0_op <= '0;
            s0_a0 <= '0; s0_b0 <= '0; s0_w0 <= '0; s0_a1 <= '0; s0_b1 <= '0; s0_w1 <= '0;
            s1_vld <= 1'b0; s1_op <= '0;
            s1_x0 <= '0; s1_y0 <= '0; s1_x1 <= '0; s1_y1 <= '0; s1_p0 <= '0; s1_p1 <= '0;
            m_vld <= '0;
            for (int i = 0; i < L; i++) begin
                m_op[i] <= '0; m_m0[i] <= '0; m_m1[i] <= '0; m_p0[i] <= '0; m_p1[i] <= '0;
            end
            out_valid <= 1'b0; out_opcode <= '0;
            out_d0 <= '0; out_d1 <= '0; out_d2 <= '0; out_d3 <= '0;
        end else begin
            if (en) begin
                s0_vld <= in_valid; s0_op <= opcode;
                s0_a0 <= a0; s0_b0 <= b0; s0_w0 <= w0; s0_a1 <= a1; s0_b1 <= b1; s0_w1 <= w1;
                s1_vld <= s0_vld; s1_op <= s0_op;
                s1_x0 <= pre_x0; s1_y0 <= pre_y0; s1_x1 <= pre_x1; s1_y1 <= pre_y1;
                s1_p0 <= pre_p0; s1_p1 <= pre_p1;
                m_vld[0] <= s1_vld; m_op[0] <= s1_op;
                m_m0[0] <= prod0; m_m1[0] <= prod1; m_p0[0] <= s1_p0; m_p1[0] <= s1_p1;
                for (int i = 1; i < L; i++) begin
                    m_vld[i] <= m_vld[i-1]; m_op[i] <= m_op[i-1];
                    m_m0[i] <= m_m0[i-1]; m_m1[i] <= m_m1[i-1];
                    m_p0[i] <= m_p0[i-1]; m_p1[i] <= m_p1[i-1];
                end
                out_valid <= m_vld[L-1]; out_opcode <= m_op[L-1];
                out_d0 <= post_d0; out_d1 <= post_d1; out_d2 <= post_d2; out_d3 <= post_d3;
            end
            // Flush wins over the enable so even a stalled pipe empties in one edge.
            if (flush) begin
                s0_vld <= 1'b0; s1_vld <= 1'b0; m_vld <= '0; out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rbfu_pipe.sv
// Directed bench for rbfu_pipe: one MUL_LAT=1 and one MUL_LAT=3 instance share all stimulus.
module tb_rbfu_pipe;
    localparam int PW = 24;

    logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [1:0] opcode = '0;
    logic [PW-1:0] a0 = '0, b0 = '0, w0 = '0, a1 = '0, b1 = '0, w1 = '0;

    logic o1_rdy, o1_vld, o1_busy, o3_rdy, o3_vld, o3_busy;
    logic [1:0] o1_op, o3_op;
    logic [PW-1:0] o1_d0, o1_d1, o1_d2, o1_d3, o3_d0, o3_d1, o3_d2, o3_d3;

    rbfu_pipe #(.DATA_WIDTH(12), .Q(3329), .PAIRS(2), .MUL_LAT(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o1_rdy),
        .opcode(opcode), .a0(a0), .b0(b0), .w0(w0), .a1(a1), .b1(b1), .w1(w1),
        .out_valid(o1_vld), .out_ready(out_ready), .dout0(o1_d0), .dout1(o1_d1),
        .dout2(o1_d2), .dout3(o1_d3), .out_opcode(o1_op), .busy(o1_busy));

    rbfu_pipe #(.DATA_WIDTH(12), .Q(3329), .PAIRS(2), .MUL_LAT(3)) u3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o3_rdy),
        .opcode(opcode), .a0(a0), .b0(b0), .w0(w0), .a1(a1), .b1(b1), .w1(w1),
        .out_valid(o3_vld), .out_ready(out_ready), .dout0(o3_d0), .dout1(o3_d1),
        .dout2(o3_d2), .dout3(o3_d3), .out_opcode(o3_op), .busy(o3_busy));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [1:0]    v_op [4];
    logic [PW-1:0] v_a0 [4], v_b0 [4], v_w0 [4], v_a1 [4], v_b1 [4], v_w1 [4];
    logic [PW-1:0] e_d0 [4], e_d1 [4], e_d2 [4], e_d3 [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i);
        opcode = v_op[i];
        a0 = v_a0[i]; b0 = v_b0[i]; w0 = v_w0[i];
        a1 = v_a1[i]; b1 = v_b1[i]; w1 = v_w1[i];
    endtask

    task automatic check_out1(input string tag, input int i);
        chk({tag, "_op"}, 32'(o1_op), 32'(v_op[i]));
        chk({tag, "_d0"}, 32'(o1_d0), 32'(e_d0[i]));
        chk({tag, "_d1"}, 32'(o1_d1), 32'(e_d1[i]));
        chk({tag, "_d2"}, 32'(o1_d2), 32'(e_d2[i]));
        chk({tag, "_d3"}, 32'(o1_d3), 32'(e_d3[i]));
    endtask

    task automatic run_one(input int i);
        int lat;
        drive(i);
        in_valid = 1'b1;
        #1;
        chk($sformatf("v%0d_in_ready", i), 32'(o1_rdy), 1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!o1_vld && lat < 12) begin
            tick();
            lat++;
        end
        chk($sformatf("v%0d_latency", i), lat, 3);
        check_out1($sformatf("v%0d", i), i);
        repeat (4) tick();
    endtask

    initial begin
        int tx, rx, seen;
        logic prev_stall;
        logic [PW-1:0] sv_d0, sv_d3;
        logic [1:0] sv_op;

        // NTT: pair0 (5,7,3 | 100,200,17), pair1 (3328,3328,3328 | 0,3328,1)
        v_op[0] = 2'b00;
        v_a0[0] = {12'd3328, 12'd5};   v_b0[0] = {12'd3328, 12'd7};   v_w0[0] = {12'd3328, 12'd3};
        v_a1[0] = {12'd0, 12'd100};    v_b1[0] = {12'd3328, 12'd200}; v_w1[0] = {12'd1, 12'd17};
        e_d0[0] = {12'd0, 12'd26};     e_d1[0] = {12'd3327, 12'd3313};
        e_d2[0] = {12'd3328, 12'd171}; e_d3[0] = {12'd1, 12'd29};
        // INTT: pair0 (4,10,2 | 0,1,1), pair1 (0,1,1 | 3328,3328,5)
        v_op[1] = 2'b01;
        v_a0[1] = {12'd0, 12'd4};      v_b0[1] = {12'd1, 12'd10};     v_w0[1] = {12'd1, 12'd2};
        v_a1[1] = {12'd3328, 12'd0};   v_b1[1] = {12'd3328, 12'd1};   v_w1[1] = {12'd5, 12'd1};
        e_d0[1] = {12'd1665, 12'd7};   e_d1[1] = {12'd1665, 12'd6};
        e_d2[1] = {12'd3328, 12'd1665}; e_d3[1] = {12'd0, 12'd1665};
        // PWM0: pair0 (1,2,3,4), pair1 (3328,3328,3328,2); w ignored
        v_op[2] = 2'b10;
        v_a0[2] = {12'd3328, 12'd1};   v_b0[2] = {12'd3328, 12'd2};   v_w0[2] = {12'd0, 12'd9};
        v_a1[2] = {12'd3328, 12'd3};   v_b1[2] = {12'd2, 12'd4};      v_w1[2] = {12'd0, 12'd9};
        e_d0[2] = {12'd3327, 12'd3};   e_d1[2] = {12'd1, 12'd7};
        e_d2[2] = {12'd1, 12'd3};      e_d3[2] = {12'd3327, 12'd8};
        // PWM1: pair0 (1,2,3,4,w1=6), pair1 zero boundary (2,3,1,5,w1=0)
        v_op[3] = 2'b11;
        v_a0[3] = {12'd2, 12'd1};      v_b0[3] = {12'd3, 12'd2};      v_w0[3] = {12'd7, 12'd0};
        v_a1[3] = {12'd1, 12'd3};      v_b1[3] = {12'd5, 12'd4};      v_w1[3] = {12'd0, 12'd6};
        e_d0[3] = {12'd1, 12'd27};     e_d1[3] = {12'd0, 12'd3324};
        e_d2[3] = '0;                  e_d3[3] = '0;

        #12;
        chk("rst_out_valid", 32'(o1_vld), 0);
        chk("rst_busy", 32'(o1_busy), 0);
        chk("rst_dout0", 32'(o1_d0), 0);
        chk("rst_out_opcode", 32'(o1_op), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rel_in_ready", 32'(o1_rdy), 1);

        for (int i = 0; i < 4; i++) run_one(i);

        // Back-to-back stream cycling opcodes, out_ready low for 4 cycles mid-stream.
        tx = 0; rx = 0; prev_stall = 1'b0; sv_d0 = '0; sv_d3 = '0; sv_op = '0;
        for (int c = 0; c < 60 && rx < 8; c++) begin
            out_ready = !(c >= 5 && c < 9);
            in_valid = (tx < 8);
            drive(tx % 4);
            #1;
            if (prev_stall) begin
                chk("stall_hold_vld", 32'(o1_vld), 1);
                chk("stall_hold_d0", 32'(o1_d0), 32'(sv_d0));
                chk("stall_hold_d3", 32'(o1_d3), 32'(sv_d3));
                chk("stall_hold_op", 32'(o1_op), 32'(sv_op));
            end
            chk($sformatf("stream_in_ready_c%0d", c), 32'(o1_rdy), 32'(!(o1_vld && !out_ready)));
            if (o1_vld && out_ready) begin
                check_out1($sformatf("stream_rx%0d", rx), rx % 4);
                rx++;
            end
            prev_stall = o1_vld && !out_ready;
            sv_d0 = o1_d0; sv_d3 = o1_d3; sv_op = o1_op;
            if (in_valid && o1_rdy) tx++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_rx_count", rx, 8);
        chk("stream_tx_count", tx, 8);
        seen = 0;
        repeat (10) begin
            tick();
            if (o1_vld) seen++;
        end
        chk("stream_no_extra", seen, 0);

        // Flush with 3 in flight; the input offered in the flush cycle is dropped.
        for (int k = 0; k < 3; k++) begin
            drive(k);
            in_valid = 1'b1;
            tick();
        end
        drive(3);
        flush = 1'b1;
        #1;
        chk("pre_flush_busy3", 32'(o3_busy), 1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy3", 32'(o3_busy), 0);
        chk("flush_vld3", 32'(o3_vld), 0);
        chk("flush_busy1", 32'(o1_busy), 0);
        seen = 0;
        repeat (10) begin
            tick();
            if (o3_vld || o1_vld) seen++;
        end
        chk("flush_no_out", seen, 0);

        // Reset mid-stream on the MUL_LAT=3 instance.
        for (int k = 0; k < 6; k++) begin
            drive(k % 4);
            in_valid = 1'b1;
            tick();
            if (k == 4) chk("lat5_early_vld3", 32'(o3_vld), 0);
        end
        chk("lat5_vld3", 32'(o3_vld), 1);
        chk("lat5_d0_3", 32'(o3_d0), 32'(e_d0[0]));
        chk("lat5_d1_3", 32'(o3_d1), 32'(e_d1[0]));
        #2;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_vld3", 32'(o3_vld), 0);
        chk("midrst_busy3", 32'(o3_busy), 0);
        chk("midrst_d0_3", 32'(o3_d0), 0);
        chk("midrst_vld1", 32'(o1_vld), 0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (o3_vld || o1_vld) seen++;
        end
        chk("midrst_no_out", seen, 0);
        chk("midrst_in_ready3", 32'(o3_rdy), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rbfu_pipe.md
Name: rbfu_pipe

Overview:
- Multi-lane, fully pipelined reconfigurable butterfly unit for the Kyber-class polynomial arithmetic datapath (q = 3329 by default).
- Each of PAIRS lane-pairs performs NTT, INTT, PWM0 or PWM1 on (a0,b0,w0,a1,b1,w1).
- The opcode is captured per transaction and travels with its data, so modes can change every cycle.
- A valid/ready handshake with backpressure stall, a synchronous flush and a busy flag let the memory/address controller stream data without fixed-latency bookkeeping.

Parameters:
- DATA_WIDTH, 12, coefficient width in bits; must satisfy Q < 2^DATA_WIDTH.
- Q, 3329, odd modulus.
- PAIRS, 2, number of lane-pairs; each pair has 2 butterflies and 4 outputs.
- MUL_LAT, 1, modular-multiplier pipeline depth in cycles, ≥ 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all in-flight valid bits.
- in_valid  in  1  input transaction present.
- in_ready  out  1  unit can accept this cycle.
- opcode  in  2  00 NTT, 01 INTT, 10 PWM0, 11 PWM1; sampled on accept.
- a0,b0,w0,a1,b1,w1  in  PAIRS*DATA_WIDTH each  per-pair operands; pair p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- dout0..dout3  out  PAIRS*DATA_WIDTH each  per-pair results, same packing.
- out_opcode  out  2  opcode of the presented result.
- busy  out  1  any stage holds a valid transaction.

Behaviour:
- Reset (rst=0, asynchronous): all stage valid bits cleared; out_valid=0, dout0..3=0, out_opcode=0, busy=0. in_ready=1 after release.
- Operand range: inputs must be in [0,Q). Every output is fully reduced to [0,Q); the value Q is never emitted.
- Stall: en = !(out_valid && !out_ready). in_ready = en.
  - Accept occurs when in_valid && in_ready.
  - When en=0, every stage, including data and opcode, holds.
  - Bubbles propagate as valid=0 and are not compressed.
- Latency: with no stall, out_valid rises exactly MUL_LAT+2 cycles after the accept edge.
  - Stage 0: input register plus pre-add/sub/select.
  - MUL_LAT stages: multiplier.
  - Final stage: post-add/sub/div2/select register.
  - Throughput is 1 transaction/cycle.
- Per-pair arithmetic (mod Q; x/2 means x>>1 if x even, else (x+Q)>>1):
  - NTT: d0=a0+b0*w0, d1=a0-b0*w0, d2=a1+b1*w1, d3=a1-b1*w1.
  - INTT: d0=(a0+b0)/2, d1=(b0-a0)*w0/2, d2=(a1+b1)/2, d3=(b1-a1)*w1/2.
  - PWM0: d0=a0+b0, d1=a1+b1, d2=a0*a1, d3=b0*b1.
  - PWM1: d0=a1+b1*w1, d1=a0*b0-a1-b1, d2=0, d3=0.
- Modular add/sub: compute in DATA_WIDTH+1 bits, then one conditional correction by ±Q. The multiplier returns a fully reduced product.
- Opcode: the output mux uses the pipelined opcode (out_opcode), never the live opcode input.
- Flush: clears all valid bits at the next edge regardless of en.
  - An input accepted in the flush cycle is discarded.
  - Data registers may keep stale values; dout is don't-care while out_valid=0.
- Simultaneous in_valid and a stall: no accept; the upstream must hold its operands.
- out_valid && out_ready in the same cycle as a new accept: both complete, and the pipe advances.
- busy = OR of all stage valid bits, including the output stage.
- Reset asserted mid-operation: all in-flight work is lost immediately, and no partial result is emitted after release.

Test Plan:
- NTT, PAIRS=2, Q=3329, pair0 a0=5 b0=7 w0=3 -> d0=26, d1=3313; out_valid exactly 3 cycles after accept (MUL_LAT=1).
- INTT, a0=4 b0=10 w0=2 -> d0=7, d1=6; odd case a0=0 b0=1 w0=1 -> d0=1665, d1=1665.
- PWM0, a0=1 b0=2 a1=3 b1=4 -> d0=3, d1=7, d2=3, d3=8. PWM1, a0=1 b0=2 a1=3 b1=4 w1=6 -> d0=27, d1=3324, d2=d3=0.
- PWM1 zero boundary, a0=2 b0=3 a1=1 b1=5 -> d1=0 (not 3329).
- Back-to-back stream cycling NTT/INTT/PWM0/PWM1 every cycle, with out_ready low for 4 cycles mid-stream:
  - no loss, duplication or reordering;
  - dout and out_opcode stay stable while stalled;
  - in_ready is low only while the output is full and out_ready is low.
- Robustness, repeated with MUL_LAT=3 (latency 5):
  - flush with 3 transactions in flight -> no out_valid afterwards, busy=0 next cycle;
  - rst pulse low mid-stream -> outputs 0 immediately and no spurious out_valid after release.
